sync_sp_ram_arb: RTL and testbench



---
 rtl/sync_sp_ram_arb_pkg.sv | 22 ++
 rtl/sync_sp_ram_arb_rr_arb2.sv | 35 +++
 rtl/sync_sp_ram_arb.sv | 155 +++++++++++++++
 tb/tb_sync_sp_ram_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_sp_ram_arb_pkg.sv
// Shared types and widths for the two-port RAM arbiter.
package sync_sp_ram_arb_pkg;

  localparam int unsigned NUM_PORTS      = 2;
  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned BE_WIDTH       = 8;
  // Widest RAM address the request payload can carry.
  localparam int unsigned ADDR_MAX_WIDTH = 32;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_e;

  typedef struct packed {
    logic                      we;
    logic [BE_WIDTH-1:0]       ben;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [ADDR_MAX_WIDTH-1:0] addr;
  } ram_req_t;

endpackage

// File: rtl/sync_sp_ram_arb_rr_arb2.sv
// Two-input round-robin grant with a priority pointer that flips to the
// other port after every accepted request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  // Combinational grant: lone requester wins, ties go to the pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves to the port that did not just win; holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (|gnt) begin
      prio <= gnt[0];
    end
  end

endmodule

// File: rtl/sync_sp_ram_arb.sv
// Round-robin sequencer for a single-port byte-enabled 64-bit RAM.
// Define SYNC_SP_RAM_ARB_INIT_EN to zero-fill the RAM after reset before
// any request is granted.
module sync_sp_ram_arb
  import sync_sp_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned OUT_REGS   = 0
) (
  input  logic                                   Clk_CI,
  input  logic                                   Rst_SI,
  input  logic [NUM_PORTS-1:0]                   Req_SI,
  input  logic [NUM_PORTS-1:0]                   We_SI,
  input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]     BEn_DI,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   WData_DI,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   Addr_DI,
  output logic [NUM_PORTS-1:0]                   Gnt_SO,
  output logic [NUM_PORTS-1:0]                   RValid_SO,
  output logic [DATA_WIDTH-1:0]                  RData_DO,
  output logic                                   InitDone_SO,
  output logic                                   RamCSel_SO,
  output logic                                   RamWrEn_SO,
  output logic [BE_WIDTH-1:0]                    RamBEn_SO,
  output logic [DATA_WIDTH-1:0]                  RamWrData_DO,
  output logic [ADDR_WIDTH-1:0]                  RamAddr_DO,
  input  logic [DATA_WIDTH-1:0]                  RamRdData_DI
);

  localparam int unsigned LAT = 1 + OUT_REGS;

  if (64'(DATA_DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_depth_chk
    $error("DATA_DEPTH exceeds the address range");
  end

  ram_req_t                 reqs [NUM_PORTS];
  ram_req_t                 sel;
  logic [NUM_PORTS-1:0]     gnt;
  logic                     run;
  logic                     init_act;
  logic [ADDR_WIDTH-1:0]    init_addr;
  logic [LAT-1:0]           pipe_vld;
  logic [LAT-1:0]           pipe_port;
  logic                     unused_addr_hi;

`ifdef SYNC_SP_RAM_ARB_INIT_EN
  arb_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic                  init_wr;

  // State and sweep-counter register; reset restarts the sweep at 0.
  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Sweep one word per cycle, then hand over to arbitration.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_wr    = 1'b0;
    case (state)
      INIT: begin
        init_wr = 1'b1;
        if (cnt == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  assign run         = (state == RUN);
  assign init_act    = init_wr & ~Rst_SI;
  assign init_addr   = cnt;
  assign InitDone_SO = run;
`else
  assign run         = 1'b1;
  assign init_act    = 1'b0;
  assign init_addr   = '0;
  assign InitDone_SO = 1'b1;
`endif

  // Pack each port's payload into the shared request type.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      reqs[i] = '{we:    We_SI[i],
                  ben:   BEn_DI[i],
                  wdata: WData_DI[i],
                  addr:  ADDR_MAX_WIDTH'(Addr_DI[i])};
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk (Clk_CI),
    .rst (Rst_SI),
    .en  (run & ~Rst_SI),
    .req (Req_SI),
    .gnt (gnt)
  );

  assign Gnt_SO = gnt;
  assign sel    = gnt[1] ? reqs[1] : reqs[0];
  assign unused_addr_hi = ^(sel.addr >> ADDR_WIDTH);

  // RAM port drive: init sweep, granted request, or all-zero idle.
  always_comb begin
    RamCSel_SO   = 1'b0;
    RamWrEn_SO   = 1'b0;
    RamBEn_SO    = '0;
    RamWrData_DO = '0;
    RamAddr_DO   = '0;
    if (init_act) begin
      RamCSel_SO = 1'b1;
      RamWrEn_SO = 1'b1;
      RamBEn_SO  = '1;
      RamAddr_DO = init_addr;
    end else if (|(Req_SI & gnt)) begin
      RamCSel_SO   = 1'b1;
      RamWrEn_SO   = sel.we;
      RamBEn_SO    = sel.ben;
      RamWrData_DO = sel.wdata;
      RamAddr_DO   = ADDR_WIDTH'(sel.addr);
    end
  end

  // Read-return tracker matching the RAM read latency.
  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      pipe_vld  <= '0;
      pipe_port <= '0;
    end else begin
      pipe_vld[0]  <= (|(Req_SI & gnt)) & ~sel.we;
      pipe_port[0] <= gnt[1];
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_port[i] <= pipe_port[i-1];
      end
    end
  end

  // Responses still in flight when reset arrives are suppressed.
  assign RValid_SO = (pipe_vld[LAT-1] & ~Rst_SI)
                   ? (pipe_port[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
  assign RData_DO  = RamRdData_DI;

endmodule

// File: tb/tb_sync_sp_ram_arb.sv
// Randomized bench for sync_sp_ram_arb with a behavioural RAM and a
// reference model of arbitration, memory contents and read returns.
module tb_sync_sp_ram_arb;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned OREGS = 0;
  localparam int unsigned LAT   = 1 + OREGS;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, we;
  logic [1:0][7:0]  ben;
  logic [1:0][63:0] wdata;
  logic [1:0][AW-1:0] addr;
  logic [1:0]       gnt, rvalid;
  logic [63:0]      rdata;
  logic             init_done, ram_csel, ram_we;
  logic [7:0]       ram_ben;
  logic [63:0]      ram_wdata, ram_rdata;
  logic [AW-1:0]    ram_addr;

  always #5 clk = ~clk;

  sync_sp_ram_arb #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(OREGS)) dut (
    .Clk_CI(clk), .Rst_SI(rst), .Req_SI(req), .We_SI(we), .BEn_DI(ben),
    .WData_DI(wdata), .Addr_DI(addr), .Gnt_SO(gnt), .RValid_SO(rvalid),
    .RData_DO(rdata), .InitDone_SO(init_done), .RamCSel_SO(ram_csel),
    .RamWrEn_SO(ram_we), .RamBEn_SO(ram_ben), .RamWrData_DO(ram_wdata),
    .RamAddr_DO(ram_addr), .RamRdData_DI(ram_rdata)
  );

  // Behavioural read-first single-port RAM
  logic [63:0] ram [DEPTH];
  logic [63:0] ram_q [LAT];
  always @(posedge clk) begin
    if (ram_csel) begin
      if (ram_we) begin
        for (int b = 0; b < 8; b++)
          if (ram_ben[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_q[0] <= ram[ram_addr];
      end
    end
    for (int i = 1; i < LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign ram_rdata = ram_q[LAT-1];

  // Reference model state
  typedef struct {
    int          due;
    int          port;
    logic [63:0] data;
    bit          kn;
  } rsp_t;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          prio_m = 0;
  int          init_left = 0;
  logic [63:0] gold [DEPTH];
  bit          known [DEPTH];
  rsp_t        q [$];
  logic [1:0]  last_gnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Check one cycle at the falling edge, update the model, advance.
  task automatic tick();
    logic [1:0] eg;
    logic [1:0] erv;
    int p;
    int a;
    rsp_t r;
    @(negedge clk);
    eg = 2'b00;
    if (rst) begin
      check_eq("rst_gnt", 64'(gnt), 0);
      check_eq("rst_rvalid", 64'(rvalid), 0);
      check_eq("rst_csel", 64'(ram_csel), 0);
      check_eq("rst_wren", 64'(ram_we), 0);
`ifdef SYNC_SP_RAM_ARB_INIT_EN
      check_eq("rst_initdone", 64'(init_done), 0);
      init_left = DEPTH;
`else
      check_eq("rst_initdone", 64'(init_done), 1);
      init_left = 0;
`endif
      q.delete();
      prio_m = 0;
    end else begin
      check_eq("initdone", 64'(init_done), 64'(init_left == 0));
      if (init_left == 0) begin
        if (req == 2'b11) eg = (prio_m == 0) ? 2'b01 : 2'b10;
        else              eg = req;
      end
      check_eq("gnt", 64'(gnt), 64'(eg));
      erv = 2'b00;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        erv = (r.port == 0) ? 2'b01 : 2'b10;
        if (r.kn) check_eq("rdata", rdata, r.data);
      end
      check_eq("rvalid", 64'(rvalid), 64'(erv));
      check_eq("csel", 64'(ram_csel), 64'((init_left > 0) || (eg != 0)));
      if (init_left > 0) begin
        a = DEPTH - init_left;
        check_eq("init_addr", 64'(ram_addr), 64'(a));
        gold[a] = 64'h0;
        known[a] = 1'b1;
        init_left--;
      end else if (eg != 0) begin
        p = eg[1] ? 1 : 0;
        a = int'(addr[p]);
        check_eq("ram_addr", 64'(ram_addr), 64'(a));
        if (we[p]) begin
          for (int b = 0; b < 8; b++)
            if (ben[p][b]) gold[a][8*b +: 8] = wdata[p][8*b +: 8];
          known[a] = 1'b1;
        end else begin
          q.push_back('{due: cyc + LAT, port: p, data: gold[a], kn: known[a]});
        end
        prio_m = 1 - p;
      end else begin
        check_eq("idle_addr", 64'(ram_addr), 0);
      end
    end
    last_gnt = eg;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input int p, input bit w, input logic [7:0] be,
                       input logic [63:0] d, input int a);
    req = 2'b00;
    req[p] = 1'b1;
    we[p] = w;
    ben[p] = be;
    wdata[p] = d;
    addr[p] = AW'(a);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_gnt[p]) break;
    end
    check_eq("issue_gnt", 64'(last_gnt[p]), 1);
    req[p] = 1'b0;
  endtask

  task automatic drain();
    req = 2'b00;
    repeat (LAT + 2) tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; we = '0; ben = '0; wdata = '0; addr = '0;
    last_gnt = '0;
    for (int i = 0; i < DEPTH; i++) begin gold[i] = '0; known[i] = 1'b0; end
    @(posedge clk); #1;
    repeat (3) tick();
    rst = 1'b0;

    // Requests held through init must stay ungranted until ready
    req = 2'b11; we = 2'b00; addr[0] = AW'(15); addr[1] = AW'(15);
    n = 0;
    while (!init_done && n < 100) begin tick(); n++; end
`ifdef SYNC_SP_RAM_ARB_INIT_EN
    check_eq("init_cycles", 64'(n), 64'(DEPTH));
`else
    check_eq("init_cycles", 64'(n), 0);
`endif
    repeat (2) tick();
    drain();

    // Give every word a defined value
    for (int a = 0; a < DEPTH; a++) issue(0, 1'b1, 8'hFF, {$urandom, $urandom}, a);

    // Single read
    issue(0, 1'b1, 8'hFF, 64'h1122334455667788, 5);
    issue(0, 1'b0, 8'h00, 64'h0, 5);
    drain();

    // Byte enables
    issue(1, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    issue(1, 1'b1, 8'h0F, 64'h0, 3);
    issue(0, 1'b0, 8'h00, 64'h0, 3);
    check_eq("ben_gold", gold[3], 64'hFFFFFFFF00000000);
    drain();

    // Contention: continuous reads from both ports
    req = 2'b11; we = 2'b00; addr[0] = AW'(5); addr[1] = AW'(3);
    repeat (8) tick();
    drain();

    // Read followed by write to the same word
    issue(0, 1'b1, 8'hFF, 64'hA, 7);
    issue(1, 1'b0, 8'h00, 64'h0, 7);
    issue(0, 1'b1, 8'hFF, 64'hB, 7);
    issue(1, 1'b0, 8'h00, 64'h0, 7);
    drain();

    // Random traffic; a pending request keeps its payload until granted
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || last_gnt[p]) begin
          req[p]   = ($urandom_range(0, 3) != 0);
          we[p]    = $urandom_range(0, 1) != 0;
          ben[p]   = 8'($urandom);
          wdata[p] = {$urandom, $urandom};
          addr[p]  = AW'($urandom);
        end
      end
      tick();
    end
    drain();

    // Reset right after an accepted read
    issue(0, 1'b0, 8'h00, 64'h0, 5);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    req = 2'b11; we = 2'b00; addr[0] = AW'(1); addr[1] = AW'(2);
    n = 0;
    do begin tick(); n++; end while (last_gnt == 2'b00 && n < 40);
    check_eq("prio_after_rst", 64'(last_gnt), 64'(2'b01));
    drain();

    check_eq("pending_rsp", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
